// File: rtl/wr_drv_seq.sv
// SRAM write-driver sequencer: precharge, word-line drive, recover, done.
// Optional macro WR_DRV_NEG_ASSIST_EN pulls the low side of written columns to VNEG_LVL.
module wr_drv_seq #(
    parameter int  COLS     = 8,
    parameter int  PRE_CYC  = 2,
    parameter int  DRV_CYC  = 3,
    parameter real VDD_LVL  = 1.0,
    parameter real VNEG_LVL = -0.1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_req,
    input  logic [COLS-1:0] data_in,
    input  logic [COLS-1:0] wr_mask,
    output logic            wr_ack,
    output logic            busy,
    output logic            pre_en,
    output logic            wl_en,
    output logic            done,
    output real             bl_wr  [COLS],
    output real             blb_wr [COLS]
);

    localparam int MAX_CYC = (PRE_CYC > DRV_CYC) ? PRE_CYC : DRV_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(PRE_CYC - 32'sd1);
    localparam logic [CW-1:0] CNT_DRV_LAST = CW'(DRV_CYC - 32'sd1);

`ifdef WR_DRV_NEG_ASSIST_EN
    localparam bit NEG_ASSIST = 1'b1;
`else
    localparam bit NEG_ASSIST = 1'b0;
`endif

    // Level applied to the pulled-down side of a written column.
    localparam real LOW_LVL = NEG_ASSIST ? VNEG_LVL : 0.0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DRV  = 3'd2,
        ST_REC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          state_r;
    state_t          nxt_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   nxt_cnt_s;
    logic            accept_s;
    logic [COLS-1:0] data_r;
    logic [COLS-1:0] mask_r;
    logic [COLS-1:0] nxt_bl_lo_s;
    logic [COLS-1:0] nxt_blb_lo_s;
    logic [COLS-1:0] bl_lo_r;
    logic [COLS-1:0] blb_lo_r;
    logic            wr_ack_r;
    logic            busy_r;
    logic            pre_en_r;
    logic            wl_en_r;
    logic            done_r;

    // State and phase-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
        end
    end

    // Next-state and phase-counter logic; the counter is reloaded on every state entry.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_req) begin
                    accept_s    = 1'b1;
                    nxt_state_s = ST_PRE;
                    nxt_cnt_s   = CNT_PRE_LAST;
                end else begin
                    nxt_state_s = ST_IDLE;
                    nxt_cnt_s   = '0;
                end
            end
            ST_PRE: begin
                if (cnt_r == '0) begin
                    nxt_state_s = ST_DRV;
                    nxt_cnt_s   = CNT_DRV_LAST;
                end else begin
                    nxt_state_s = ST_PRE;
                    nxt_cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_DRV: begin
                if (cnt_r == '0) begin
                    nxt_state_s = ST_REC;
                    nxt_cnt_s   = '0;
                end else begin
                    nxt_state_s = ST_DRV;
                    nxt_cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_REC: begin
                nxt_state_s = ST_DONE;
                nxt_cnt_s   = '0;
            end
            ST_DONE: begin
                nxt_state_s = ST_IDLE;
                nxt_cnt_s   = '0;
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_cnt_s   = '0;
            end
        endcase
    end

    // Write data and mask are captured only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            mask_r <= '0;
        end else if (accept_s) begin
            data_r <= data_in;
            mask_r <= wr_mask;
        end
    end

    // Per-column pull-down selection for the upcoming cycle; unmasked columns stay precharged.
    always_comb begin
        nxt_bl_lo_s  = '0;
        nxt_blb_lo_s = '0;
        if (nxt_state_s == ST_DRV) begin
            nxt_bl_lo_s  = mask_r & ~data_r;
            nxt_blb_lo_s = mask_r & data_r;
        end else begin
            nxt_bl_lo_s  = '0;
            nxt_blb_lo_s = '0;
        end
    end

    // Output registers, decoded from the state being entered so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_r <= 1'b0;
            busy_r   <= 1'b0;
            pre_en_r <= 1'b1;
            wl_en_r  <= 1'b0;
            done_r   <= 1'b0;
            bl_lo_r  <= '0;
            blb_lo_r <= '0;
        end else begin
            wr_ack_r <= accept_s;
            busy_r   <= (nxt_state_s != ST_IDLE);
            pre_en_r <= (nxt_state_s != ST_DRV);
            wl_en_r  <= (nxt_state_s == ST_DRV);
            done_r   <= (nxt_state_s == ST_DONE);
            bl_lo_r  <= nxt_bl_lo_s;
            blb_lo_r <= nxt_blb_lo_s;
        end
    end

    assign wr_ack = wr_ack_r;
    assign busy   = busy_r;
    assign pre_en = pre_en_r;
    assign wl_en  = wl_en_r;
    assign done   = done_r;

    for (genvar g = 0; g < COLS; g++) begin : g_col
        assign bl_wr[g]  = bl_lo_r[g]  ? LOW_LVL : VDD_LVL;
        assign blb_wr[g] = blb_lo_r[g] ? LOW_LVL : VDD_LVL;
    end

endmodule

// File: tb/tb_wr_drv_seq.sv
// Scoreboard bench for wr_drv_seq: stimulus queues expected ack/drive/done events,
// a negedge monitor pops and compares them; a second instance runs PRE_CYC=DRV_CYC=1.
module tb_wr_drv_seq;

    localparam int  COLS     = 8;
    localparam int  PRE      = 2;
    localparam int  DRV      = 3;
    localparam int  PERIOD   = PRE + DRV + 3;
    localparam int  LAT_DONE = PRE + DRV + 2;
    localparam real VDD      = 1.0;
`ifdef WR_DRV_NEG_ASSIST_EN
    localparam real LOW = -0.1;
`else
    localparam real LOW = 0.0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_req = 1'b0;
    logic [COLS-1:0] data_in = '0;
    logic [COLS-1:0] wr_mask = '0;
    logic            wr_ack, busy, pre_en, wl_en, done;
    real             bl_wr  [COLS];
    real             blb_wr [COLS];

    logic            f_wr_req = 1'b0;
    logic [COLS-1:0] f_data = '0;
    logic [COLS-1:0] f_mask = '0;
    logic            f_wr_ack, f_busy, f_pre_en, f_wl_en, f_done;
    real             f_bl  [COLS];
    real             f_blb [COLS];

    wr_drv_seq #(.COLS(COLS), .PRE_CYC(PRE), .DRV_CYC(DRV)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .data_in(data_in), .wr_mask(wr_mask),
        .wr_ack(wr_ack), .busy(busy), .pre_en(pre_en), .wl_en(wl_en), .done(done),
        .bl_wr(bl_wr), .blb_wr(blb_wr)
    );

    wr_drv_seq #(.COLS(COLS), .PRE_CYC(1), .DRV_CYC(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .wr_req(f_wr_req), .data_in(f_data), .wr_mask(f_mask),
        .wr_ack(f_wr_ack), .busy(f_busy), .pre_en(f_pre_en), .wl_en(f_wl_en), .done(f_done),
        .bl_wr(f_bl), .blb_wr(f_blb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_ACK = 0, EV_DRV = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t        kind;
        int              at;
        logic [COLS-1:0] bl_lo;
        logic [COLS-1:0] blb_lo;
    } ev_t;

    ev_t sbq[$];
    int  total = 0;
    int  bad = 0;
    int  ack_seen = 0;

    task automatic check(input string nm, input bit ok, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s (cycle %0d)", nm, detail, cyc);
        end
    endtask

    task automatic chk_lines(input string nm, input logic [COLS-1:0] bl_lo,
                             input logic [COLS-1:0] blb_lo);
        int    badc;
        real   ea, eb;
        string s;
        badc = -1;
        s = "ok";
        for (int i = 0; i < COLS; i++) begin
            ea = bl_lo[i] ? LOW : VDD;
            eb = blb_lo[i] ? LOW : VDD;
            if ((bl_wr[i] != ea || blb_wr[i] != eb) && badc < 0) begin
                badc = i;
                s = $sformatf("col %0d got bl=%f blb=%f, want bl=%f blb=%f",
                              i, bl_wr[i], blb_wr[i], ea, eb);
            end
        end
        check(nm, badc < 0, s);
    endtask

    task automatic push_write(input int t0, input logic [COLS-1:0] bl_lo,
                              input logic [COLS-1:0] blb_lo);
        ev_t e;
        e.bl_lo = bl_lo;
        e.blb_lo = blb_lo;
        e.kind = EV_ACK;  e.at = t0 + 1;        sbq.push_back(e);
        for (int k = 1; k <= DRV; k++) begin
            e.kind = EV_DRV; e.at = t0 + PRE + k; sbq.push_back(e);
        end
        e.kind = EV_DONE; e.at = t0 + LAT_DONE; sbq.push_back(e);
    endtask

    task automatic pop_cmp(input ev_kind_t kind);
        ev_t e;
        if (sbq.size() == 0) begin
            check("unexpected", 1'b0, $sformatf("event kind %0d with empty queue", kind));
        end else begin
            e = sbq.pop_front();
            check("event", e.kind == kind && e.at == cyc,
                  $sformatf("got kind %0d at %0d, want kind %0d at %0d", kind, cyc, e.kind, e.at));
            check("busy", busy == 1'b1, $sformatf("got %0b want 1", busy));
            if (kind == EV_DRV) chk_lines("bl_drive", e.bl_lo, e.blb_lo);
        end
    endtask

    // Monitor: flags overdue events, then pops one expected event per presented output.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sbq.size() > 0 && sbq[0].at < cyc) begin
                check("missed", 1'b0, $sformatf("kind %0d due at %0d not seen", sbq[0].kind, sbq[0].at));
                void'(sbq.pop_front());
            end
            if (wr_ack) begin
                ack_seen++;
                pop_cmp(EV_ACK);
            end
            if (wl_en) pop_cmp(EV_DRV);
            if (done) pop_cmp(EV_DONE);
            if (!wl_en) chk_lines("bl_precharged", '0, '0);
            if (!done) check("pre_en", pre_en == !wl_en, $sformatf("got pre_en=%0b wl_en=%0b", pre_en, wl_en));
        end
    end

    typedef struct {
        logic [COLS-1:0] data;
        logic [COLS-1:0] mask;
        logic [COLS-1:0] bl_lo;
        logic [COLS-1:0] blb_lo;
    } vec_t;

    vec_t vecs [5] = '{
        '{8'hA5, 8'hFF, 8'h5A, 8'hA5},
        '{8'h00, 8'h0F, 8'h0F, 8'h00},
        '{8'h3C, 8'hF0, 8'hC0, 8'h30},
        '{8'hFF, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'hFF, 8'hFF, 8'h00}
    };

    task automatic do_write(input vec_t v);
        @(negedge clk);
        wr_req = 1'b1;
        data_in = v.data;
        wr_mask = v.mask;
        push_write(cyc, v.bl_lo, v.blb_lo);
        @(negedge clk);
        wr_req = 1'b0;
        repeat (PERIOD - 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int t0;
        int f_ack_k, f_done_k, f_wl_k, f_wl_n;

        #12;
        check("rst_busy", busy == 1'b0, $sformatf("got %0b want 0", busy));
        check("rst_wl_en", wl_en == 1'b0, $sformatf("got %0b want 0", wl_en));
        check("rst_pre_en", pre_en == 1'b1, $sformatf("got %0b want 1", pre_en));
        check("rst_ack_done", wr_ack == 1'b0 && done == 1'b0, $sformatf("got ack=%0b done=%0b", wr_ack, done));
        chk_lines("rst_bitlines", '0, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) do_write(vecs[i]);

        // Held request: two acceptances exactly one period apart, then idle.
        a0 = ack_seen;
        @(negedge clk);
        wr_req = 1'b1;
        data_in = 8'h81;
        wr_mask = 8'hFF;
        push_write(cyc, 8'h7E, 8'h81);
        push_write(cyc + PERIOD, 8'h7E, 8'h81);
        repeat (2 * PERIOD) @(negedge clk);
        wr_req = 1'b0;
        repeat (PERIOD) @(negedge clk);
        check("held_acks", ack_seen - a0 == 2, $sformatf("got %0d acks want 2", ack_seen - a0));

        // Reset in the second drive cycle aborts the write without a done pulse.
        @(negedge clk);
        wr_req = 1'b1;
        data_in = 8'hA5;
        wr_mask = 8'hFF;
        t0 = cyc;
        push_write(t0, 8'h5A, 8'hA5);
        @(negedge clk);
        wr_req = 1'b0;
        repeat (PRE + 1) @(negedge clk);
        #2;
        check("abort_in_drive", wl_en == 1'b1 && cyc == t0 + PRE + 2, $sformatf("got wl_en=%0b cycle offset %0d", wl_en, cyc - t0));
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("abort_wl_en", wl_en == 1'b0, $sformatf("got %0b want 0", wl_en));
        check("abort_pre_busy", pre_en == 1'b1 && busy == 1'b0, $sformatf("got pre_en=%0b busy=%0b", pre_en, busy));
        chk_lines("abort_bitlines", '0, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_write(vecs[0]);

        // Minimum-length sequence on the second instance.
        f_ack_k = -1; f_done_k = -1; f_wl_k = -1; f_wl_n = 0;
        @(negedge clk);
        f_wr_req = 1'b1;
        f_data = 8'h01;
        f_mask = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) f_wr_req = 1'b0;
            if (f_wr_ack && f_ack_k < 0) f_ack_k = k;
            if (f_done && f_done_k < 0) f_done_k = k;
            if (f_wl_en) begin
                f_wl_n++;
                if (f_wl_k < 0) f_wl_k = k;
                check("fast_drive_lines", f_bl[0] == VDD && f_blb[0] == LOW && f_bl[1] == VDD && f_blb[1] == VDD,
                      $sformatf("got bl0=%f blb0=%f bl1=%f blb1=%f", f_bl[0], f_blb[0], f_bl[1], f_blb[1]));
            end
        end
        check("fast_ack", f_ack_k == 1, $sformatf("got cycle %0d want 1", f_ack_k));
        check("fast_wl", f_wl_k == 2 && f_wl_n == 1, $sformatf("got start %0d len %0d want 2/1", f_wl_k, f_wl_n));
        check("fast_done", f_done_k == 4, $sformatf("got cycle %0d want 4", f_done_k));

        repeat (5) @(negedge clk);
        check("leftover", sbq.size() == 0, $sformatf("got %0d pending want 0", sbq.size()));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
